// File: rtl/data_mem_arbiter.sv
// Two-requester front end for the single-ported 8-bit data_mem: core single accesses and host bursts.
// Optional macro ARB_CORE_PREEMPT_EN lets a core request steal one burst cycle at a time.
module data_mem_arbiter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          CoreReq,
    input  logic          CoreWrite,
    input  logic [AW-1:0] CoreAddr,
    input  logic [7:0]    CoreWData,
    output logic          CoreGnt,
    output logic [7:0]    CoreRData,
    output logic          CoreValid,
    input  logic          HostReq,
    input  logic          HostWrite,
    input  logic [AW-1:0] HostAddr,
    input  logic [AW-1:0] HostLen,
    input  logic [7:0]    HostWData,
    output logic          HostGnt,
    output logic [7:0]    HostRData,
    output logic          HostValid,
    output logic          HostDone,
    output logic [AW-1:0] MemAddr,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [7:0]    MemWData,
    input  logic [7:0]    MemRData
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          last_host_q, last_host_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [AW:0]   brem_q, brem_d;
    logic          bwrite_q, bwrite_d;

    logic [7:0]    core_rdata_q, core_rdata_d;
    logic          core_valid_q, core_valid_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic          host_valid_q, host_valid_d;
    logic          host_done_q, host_done_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;

    logic          core_sel;
    logic          host_sel;
    logic          last_beat;
    logic          access;
    logic          acc_write;
    logic [AW-1:0] acc_addr;
    logic [7:0]    acc_wdata;
    logic [AW:0]   len_full;
    logic          preempt;

    // HostLen of zero encodes a full-memory burst of 2**AW beats.
    assign len_full = (HostLen == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, HostLen};

`ifdef ARB_CORE_PREEMPT_EN
    logic stole_last_q, stole_last_d;

    assign preempt = (state_q == S_BURST) && CoreReq && !stole_last_q;

    always_comb begin
        stole_last_d = stole_last_q;
        if (host_sel) begin
            stole_last_d = 1'b0;
        end else if (core_sel && (state_q == S_BURST)) begin
            stole_last_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            stole_last_q <= 1'b0;
        end else begin
            stole_last_q <= stole_last_d;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_host_d = last_host_q;
        baddr_d     = baddr_q;
        brem_d      = brem_q;
        bwrite_d    = bwrite_q;
        core_sel    = 1'b0;
        host_sel    = 1'b0;
        last_beat   = 1'b0;
        acc_write   = 1'b0;
        acc_addr    = baddr_q;
        acc_wdata   = HostWData;

        // Reset suppresses every grant so an aborted burst cannot write.
        if (!Reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (CoreReq && (!HostReq || last_host_q)) begin
                        core_sel = 1'b1;
                    end else if (HostReq) begin
                        host_sel    = 1'b1;
                        acc_addr    = HostAddr;
                        acc_write   = HostWrite;
                        bwrite_d    = HostWrite;
                        baddr_d     = HostAddr + 1'b1;
                        brem_d      = len_full - 1'b1;
                        last_host_d = 1'b1;
                        if (brem_d == '0) begin
                            last_beat = 1'b1;
                        end else begin
                            state_d = S_BURST;
                        end
                    end
                end
                S_BURST: begin
                    if (preempt) begin
                        core_sel = 1'b1;
                    end else begin
                        host_sel  = 1'b1;
                        acc_addr  = baddr_q;
                        acc_write = bwrite_q;
                        baddr_d   = baddr_q + 1'b1;
                        brem_d    = brem_q - 1'b1;
                        if (brem_q == (AW+1)'(1)) begin
                            last_beat = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (core_sel) begin
                acc_addr    = CoreAddr;
                acc_write   = CoreWrite;
                acc_wdata   = CoreWData;
                last_host_d = 1'b0;
            end
        end
    end

    always_comb begin
        access       = core_sel | host_sel;
        CoreGnt      = core_sel;
        HostGnt      = host_sel;
        MemRead      = access & ~acc_write;
        MemWrite     = access & acc_write;
        MemAddr      = access ? acc_addr : mem_addr_q;
        MemWData     = access ? acc_wdata : mem_wdata_q;
        mem_addr_d   = MemAddr;
        mem_wdata_d  = MemWData;

        core_valid_d = core_sel & ~acc_write;
        host_valid_d = host_sel & ~acc_write;
        core_rdata_d = core_valid_d ? MemRData : core_rdata_q;
        host_rdata_d = host_valid_d ? MemRData : host_rdata_q;
        host_done_d  = last_beat;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            last_host_q  <= 1'b1;
            baddr_q      <= '0;
            brem_q       <= '0;
            bwrite_q     <= 1'b0;
            core_rdata_q <= '0;
            core_valid_q <= 1'b0;
            host_rdata_q <= '0;
            host_valid_q <= 1'b0;
            host_done_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_host_q  <= last_host_d;
            baddr_q      <= baddr_d;
            brem_q       <= brem_d;
            bwrite_q     <= bwrite_d;
            core_rdata_q <= core_rdata_d;
            core_valid_q <= core_valid_d;
            host_rdata_q <= host_rdata_d;
            host_valid_q <= host_valid_d;
            host_done_q  <= host_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign CoreRData = core_rdata_q;
    assign CoreValid = core_valid_q;
    assign HostRData = host_rdata_q;
    assign HostValid = host_valid_q;
    assign HostDone  = host_done_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported 8-bit `data_mem`. It shares the memory between two requesters:
- the processor's load/store path (core port): single accesses.
- a host/loader port: auto-incrementing bursts, used to seed or dump memory before and after a program run.

It drives `data_mem` directly, with `ReadMem` and `WriteMem` asserted only on real accesses. It registers all read data returned to requesters.

## Interface
- `AW`, 8, address width; memory depth 2**AW, burst length range 1..2**AW

- `clk`  in  1  clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `CoreReq`  in  1  core access request; held with Addr/Write/WData until `CoreGnt`
- `CoreWrite`  in  1  1 = store, 0 = load
- `CoreAddr`  in  AW  core address
- `CoreWData`  in  8  core store data
- `CoreGnt`  out  1  combinational; access performed this cycle
- `CoreRData`  out  8  registered load data
- `CoreValid`  out  1  registered; `CoreRData` valid (loads only)
- `HostReq`  in  1  burst request; sampled only in IDLE
- `HostWrite`  in  1  burst direction, latched at burst start
- `HostAddr`  in  AW  burst base address, latched at start
- `HostLen`  in  AW  beat count, latched at start; 0 means 2**AW
- `HostWData`  in  8  write beat data; must be valid in every `HostGnt` cycle
- `HostGnt`  out  1  combinational; one beat performed this cycle
- `HostRData`  out  8  registered read beat data
- `HostValid`  out  1  registered; `HostRData` valid
- `HostDone`  out  1  registered one-cycle pulse after the last beat
- `MemAddr`  out  AW  to `data_mem` `DataAddress`
- `MemRead`  out  1  to `ReadMem`; high only on read accesses
- `MemWrite`  out  1  to `WriteMem`
- `MemWData`  out  8  to `DataIn`
- `MemRData`  in  8  from `DataOut`; combinational, sampled only when `MemRead`=1

## Operation
- States: IDLE, BURST.
- Internal registers: `LastHost` (reset 1), burst address `BAddr`, remaining count `BRem` (AW+1 bits), latched `BWrite`, and `StoleLast` (reset 0).
- IDLE arbitration:
  - Only `CoreReq`: serve core.
  - Only `HostReq`: start a burst.
  - Both: round-robin. Serve the core if `LastHost`=1, else start the burst.
  - The core is therefore served first after reset.
- Core service:
  - Drive `MemAddr`=`CoreAddr` and `MemWrite`=`CoreWrite`.
  - Drive `MemRead`=!`CoreWrite` and `MemWData`=`CoreWData`.
  - Assert `CoreGnt`.
  - Set `LastHost`=0 and stay in IDLE.
- Burst start (IDLE cycle), which is beat 0:
  - Access `HostAddr` and assert `HostGnt`.
  - Latch `BWrite`=`HostWrite` and `BAddr`=`HostAddr`+1 (mod 2**AW).
  - Set `BRem`=Len−1, where Len = `HostLen`, or 2**AW if `HostLen`=0.
  - If `BRem`=0, stay in IDLE; otherwise go to BURST.
  - Set `LastHost`=1.
- BURST state, each beat:
  - Access `BAddr` with `HostGnt`=1.
  - Increment `BAddr` (wraps 2**AW−1 → 0) and decrement `BRem`.
  - When the beat with `BRem`=1 executes, return to IDLE.
- `HostReq` is ignored during BURST.
- Read return:
  - `CoreRData`/`HostRData` take `MemRData` on the cycle after the read access.
  - `CoreValid`/`HostValid` pulse for one cycle.
  - RData holds its value until the next read.
- `HostDone` pulses in the cycle after the final beat, aligned with the last `HostValid` for read bursts.
- Idle memory outputs (no access): `MemRead`=`MemWrite`=0, and `MemAddr`/`MemWData` hold their last values.
- Reset mid-burst:
  - Abort immediately; no further memory writes occur.
  - No `HostDone` pulse.
  - Return to IDLE.

## Timing
- Reset values:
  - `CoreGnt`, `HostGnt`, `CoreValid`, `HostValid`, `HostDone`, `MemRead`, `MemWrite` = 0.
  - `CoreRData`, `HostRData`, `MemAddr`, `MemWData` = 0.
  - While `Reset`=1, `CoreGnt`, `HostGnt`, `MemRead` and `MemWrite` are forced 0.
- Grant latency: 0 cycles (same cycle as request) when uncontended.
- Read data latency: 1 cycle after grant.
- Write latency: memory updated at the grant-cycle edge.
- Burst of N beats: N consecutive `HostGnt` cycles without preemption; `HostDone` at cycle N.
- No access is performed, and no grant asserted, in a cycle where the requester's Req is low.

## Configuration
- `ARB_CORE_PREEMPT_EN`
  - Defined: in BURST, if `CoreReq`=1 and `StoleLast`=0, the core is served that cycle instead of the burst beat. `HostGnt`=0, `BAddr`/`BRem` do not change, and `StoleLast` is set to 1. Any burst beat clears `StoleLast`. The core waits at most 1 cycle, and the host gets at least every other cycle.
  - Undefined: bursts run uninterrupted and the core waits until IDLE. There, `LastHost`=1 guarantees the core wins the next cycle.

## Test plan
- Core store 0x5A to 0x10, then load 0x10 → `CoreGnt` in each request cycle; `CoreValid`=1 with `CoreRData`=0x5A one cycle after the load grant.
- First cycle after reset, both requests (host Len=2) → core granted first, burst starts the next cycle; `HostDone` 2 cycles after burst start.
- Host write burst, `HostAddr`=0xFE, Len=4, data 1,2,3,4 → mem[FE]=1, [FF]=2, [00]=3, [01]=4; four consecutive `HostGnt`; `HostDone` the following cycle.
- Host read burst, `HostLen`=0 → 256 `HostValid` pulses in address order from base; `HostDone` with the 256th.
- `Reset` asserted during beat 2 of a 5-beat write burst → only beats 0 and 1 are written; all outputs 0; IDLE; a subsequent core request is granted immediately.
- `CoreReq` held during an 8-beat burst → with macro: core granted within 1 cycle and the burst completes in 9 cycles. Without macro: core granted in the cycle after the last beat.
